// File: rtl/fmps_packet_builder.sv
// fmps_packet_builder: double-banked FMPS capture, emitted as an AXI4-Stream packet.
// Optional XOR trailer word: define FMPS_PACKET_CHECKSUM_EN.
module fmps_packet_builder #(
  parameter int         INDEX_WIDTH  = 5,
  parameter logic [7:0] HEADER_MAGIC = 8'hA5
) (
  input  logic                   sysClk,
  input  logic                   sysReset,
  input  logic                   FAstrobe,
  input  logic                   fmpsEnabled,
  input  logic [INDEX_WIDTH-1:0] fmpsIndex,
  input  logic [31:0]            fmpsData,
  input  logic                   fmpsValid,
  output logic                   pktTVALID,
  input  logic                   pktTREADY,
  output logic                   pktTLAST,
  output logic [31:0]            pktTDATA,
  output logic [INDEX_WIDTH-1:0] pktTUSER,
  output logic                   busy,
  output logic                   dupStrobe,
  output logic [15:0]            overrunCount
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HEADER = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
`ifdef FMPS_PACKET_CHECKSUM_EN
  localparam logic [1:0] TRAILER = 2'd3;
  localparam bit TRL_EN = 1'b1;
`else
  localparam bit TRL_EN = 1'b0;
`endif

  logic [1:0]            state;
  logic                  cap_sel;
  logic [1:0][DEPTH-1:0] bm;
  logic [31:0]           mem [2][DEPTH];
  logic [7:0]            seq;
`ifdef FMPS_PACKET_CHECKSUM_EN
  logic [31:0]           csum;
`endif

  logic                   hs;
  logic                   accept;
  logic                   overrun;
  logic                   wsel;
  logic                   esel;
  logic                   dup_hit;
  logic                   em_nz;
  logic                   em_one;
  logic [DEPTH-1:0]       em;
  logic [DEPTH-1:0]       wr_mask;
  logic [DEPTH-1:0]       cap_next;
  logic [DEPTH-1:0]       clr_mask;
  logic [INDEX_WIDTH-1:0] nidx;
  logic [15:0]            count;
  logic [31:0]            hdr;
  logic [31:0]            nword;

  assign busy = (state != IDLE);
  assign hs   = pktTVALID & pktTREADY;

  // Frame-close decode; a word coincident with the strobe lands in the new frame
  always_comb begin
    accept   = FAstrobe & fmpsEnabled & ~busy;
    overrun  = FAstrobe & fmpsEnabled & busy;
    wsel     = accept ? ~cap_sel : cap_sel;
    esel     = ~cap_sel;
    wr_mask  = fmpsValid ? (DEPTH'(1) << fmpsIndex) : '0;
    cap_next = (FAstrobe ? '0 : bm[wsel]) | wr_mask;
    dup_hit  = fmpsValid & ~FAstrobe & bm[cap_sel][fmpsIndex];
  end

  // Lowest remaining index in the emit bank and whether it is the last one
  always_comb begin
    em   = bm[esel];
    nidx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (em[i]) nidx = i[INDEX_WIDTH-1:0];
    end
    em_nz    = |em;
    em_one   = (em & (em - DEPTH'(1))) == '0;
    clr_mask = DEPTH'(1) << nidx;
    nword    = mem[esel][nidx];
  end

  // Header for the frame being closed (capture bank becomes the emit bank)
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + 16'(bm[cap_sel][i]);
    end
    hdr = {HEADER_MAGIC, seq, count};
  end

  // Data arrays are not reset; the bitmaps decide what is valid
  always_ff @(posedge sysClk) begin
    if (fmpsValid) mem[wsel][fmpsIndex] <= fmpsData;
  end

  // Bank control, emit state machine and registered stream outputs
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state        <= IDLE;
      cap_sel      <= 1'b0;
      bm           <= '0;
      seq          <= '0;
      overrunCount <= '0;
      pktTVALID    <= 1'b0;
      pktTLAST     <= 1'b0;
      pktTDATA     <= '0;
      pktTUSER     <= '0;
      dupStrobe    <= 1'b0;
`ifdef FMPS_PACKET_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      dupStrobe <= dup_hit;
      bm[wsel]  <= cap_next;
      if (overrun && overrunCount != 16'hFFFF) begin
        overrunCount <= overrunCount + 16'd1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            cap_sel   <= ~cap_sel;
            pktTVALID <= 1'b1;
            pktTDATA  <= hdr;
            pktTUSER  <= '0;
            pktTLAST  <= (count == 16'd0) & ~TRL_EN;
`ifdef FMPS_PACKET_CHECKSUM_EN
            csum      <= hdr;
`endif
            state     <= HEADER;
          end
        end
        HEADER, DATA: begin
          if (hs) begin
            if (state == HEADER) seq <= seq + 8'd1;
            if (em_nz) begin
              pktTDATA <= nword;
              pktTUSER <= nidx;
              pktTLAST <= em_one & ~TRL_EN;
              bm[esel] <= em & ~clr_mask;
`ifdef FMPS_PACKET_CHECKSUM_EN
              csum     <= csum ^ nword;
`endif
              state    <= DATA;
            end else begin
`ifdef FMPS_PACKET_CHECKSUM_EN
              pktTDATA <= csum;
              pktTUSER <= '0;
              pktTLAST <= 1'b1;
              state    <= TRAILER;
`else
              pktTVALID <= 1'b0;
              pktTLAST  <= 1'b0;
              state     <= IDLE;
`endif
            end
          end
        end
`ifdef FMPS_PACKET_CHECKSUM_EN
        TRAILER: begin
          if (hs) begin
            pktTVALID <= 1'b0;
            pktTLAST  <= 1'b0;
            state     <= IDLE;
          end
        end
`endif
        default: begin
          pktTVALID <= 1'b0;
          pktTLAST  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmps_packet_builder.sv
// tb_fmps_packet_builder: random + directed stimulus, queue scoreboard.
// Honours FMPS_PACKET_CHECKSUM_EN to expect the trailer word.
module tb_fmps_packet_builder;

`ifdef FMPS_PACKET_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  u;
    logic        l;
  } word_t;

  logic        sysClk = 1'b0;
  logic        sysReset;
  logic        FAstrobe;
  logic        fmpsEnabled;
  logic [4:0]  fmpsIndex;
  logic [31:0] fmpsData;
  logic        fmpsValid;
  logic        pktTVALID;
  logic        pktTREADY;
  logic        pktTLAST;
  logic [31:0] pktTDATA;
  logic [4:0]  pktTUSER;
  logic        busy;
  logic        dupStrobe;
  logic [15:0] overrunCount;

  fmps_packet_builder #(.INDEX_WIDTH(5), .HEADER_MAGIC(8'hA5)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .FAstrobe(FAstrobe),
    .fmpsEnabled(fmpsEnabled), .fmpsIndex(fmpsIndex), .fmpsData(fmpsData),
    .fmpsValid(fmpsValid), .pktTVALID(pktTVALID), .pktTREADY(pktTREADY),
    .pktTLAST(pktTLAST), .pktTDATA(pktTDATA), .pktTUSER(pktTUSER),
    .busy(busy), .dupStrobe(dupStrobe), .overrunCount(overrunCount)
  );

  always #5 sysClk = ~sysClk;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int dup_cnt = 0;

  word_t       sb[$];
  logic [31:0] model_mem[32];
  logic [31:0] model_bm = '0;
  logic [7:0]  model_seq = '0;
  logic [15:0] model_ovr = '0;
  bit          dup_now = 0;
  bit          dup_exp_d = 0;
  logic [15:0] ovr_exp_d = '0;
  bit          mon_on = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected packet for the frame being closed, straight from the frame contents
  task automatic build_packet();
    int cnt = 0;
    int n = 0;
    logic [31:0] hdr;
    logic [31:0] x;
    for (int i = 0; i < 32; i++) if (model_bm[i]) cnt++;
    hdr = {8'hA5, model_seq, 16'(cnt)};
    sb.push_back('{d: hdr, u: 5'd0, l: (cnt == 0) && !CS});
    x = hdr;
    for (int i = 0; i < 32; i++) begin
      if (model_bm[i]) begin
        n++;
        sb.push_back('{d: model_mem[i], u: 5'(i), l: (n == cnt) && !CS});
        x = x ^ model_mem[i];
      end
    end
    if (CS) sb.push_back('{d: x, u: 5'd0, l: 1'b1});
    model_seq = model_seq + 8'd1;
  endtask

  // One cycle of stimulus; the block is busy exactly while words are still owed
  task automatic step(input bit v, input logic [4:0] idx, input logic [31:0] d,
                      input bit st, input bit en, input bit rdy);
    if (st) begin
      if (en && sb.size() == 0) build_packet();
      else if (en && model_ovr != 16'hFFFF) model_ovr = model_ovr + 16'd1;
      model_bm = '0;
    end
    dup_now = 0;
    if (v) begin
      dup_now = model_bm[idx];
      model_bm[idx] = 1'b1;
      model_mem[idx] = d;
    end
    fmpsValid = v;
    fmpsIndex = idx;
    fmpsData = d;
    FAstrobe = st;
    fmpsEnabled = en;
    pktTREADY = rdy;
    @(posedge sysClk);
    #1;
  endtask

  task automatic drain(input bit tog, input int lim);
    int n = 0;
    bit r = 1'b1;
    while (sb.size() != 0 && n < lim) begin
      step(0, 0, 0, 0, 0, r);
      if (tog) r = !r;
      n++;
    end
    if (sb.size() != 0) chk(0, "drain_timeout", sb.size(), 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    sysReset = 1'b1;
    fmpsValid = 0;
    FAstrobe = 0;
    pktTREADY = 0;
    model_ovr = '0;
    model_seq = '0;
    model_bm = '0;
    dup_now = 0;
    @(posedge sysClk);
    #1;
    sb.delete();
    sysReset = 1'b0;
  endtask

  always @(posedge sysClk) begin
    dup_exp_d <= dup_now;
    ovr_exp_d <= model_ovr;
  end

  bit          stall_prev = 0;
  bit          rst_prev = 0;
  logic [31:0] s_d;
  logic [4:0]  s_u;
  logic        s_l;
  word_t       mw;

  // Monitor: a word is consumed at the edge following a valid&ready sample
  always @(negedge sysClk) begin
    if (mon_on) begin
      if (stall_prev && !rst_prev) begin
        chk(pktTVALID === 1'b1, "stall_valid", 32'(pktTVALID), 1);
        chk(pktTDATA === s_d, "stall_data", pktTDATA, s_d);
        chk({pktTUSER, pktTLAST} === {s_u, s_l}, "stall_user_last",
            32'({pktTUSER, pktTLAST}), 32'({s_u, s_l}));
      end
      chk(dupStrobe === dup_exp_d, "dup", 32'(dupStrobe), 32'(dup_exp_d));
      chk(overrunCount === ovr_exp_d, "overrun", 32'(overrunCount), 32'(ovr_exp_d));
      if (dupStrobe) dup_cnt++;
      if (pktTVALID && pktTREADY && !sysReset) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          chk(0, "unexpected_word", pktTDATA, 0);
        end else begin
          mw = sb.pop_front();
          chk(pktTDATA === mw.d, "tdata", pktTDATA, mw.d);
          chk(pktTUSER === mw.u, "tuser", 32'(pktTUSER), 32'(mw.u));
          chk(pktTLAST === mw.l, "tlast", 32'(pktTLAST), 32'(mw.l));
        end
      end
    end
    stall_prev = pktTVALID && !pktTREADY;
    s_d = pktTDATA;
    s_u = pktTUSER;
    s_l = pktTLAST;
    rst_prev = sysReset;
  end

  initial begin
    int h0;
    int d0;
    sysReset = 1'b1;
    FAstrobe = 0;
    fmpsEnabled = 0;
    fmpsIndex = 0;
    fmpsData = 0;
    fmpsValid = 0;
    pktTREADY = 0;
    repeat (3) @(posedge sysClk);
    #1;
    sysReset = 1'b0;
    chk(pktTVALID === 1'b0, "rst_tvalid", 32'(pktTVALID), 0);
    chk(pktTLAST === 1'b0, "rst_tlast", 32'(pktTLAST), 0);
    chk(pktTDATA === 32'd0, "rst_tdata", pktTDATA, 0);
    chk(pktTUSER === 5'd0, "rst_tuser", 32'(pktTUSER), 0);
    chk(dupStrobe === 1'b0, "rst_dup", 32'(dupStrobe), 0);
    chk(overrunCount === 16'd0, "rst_ovr", 32'(overrunCount), 0);
    chk(busy === 1'b0, "rst_busy", 32'(busy), 0);
    mon_on = 1;

    // three words out of order, then close
    step(1, 3, 32'h11, 0, 0, 1);
    step(1, 7, 32'h22, 0, 0, 1);
    step(1, 1, 32'h33, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    drain(0, 50);

    // empty frame
    step(0, 0, 0, 1, 1, 1);
    drain(0, 50);

    // full frame with ready toggling every cycle
    for (int i = 0; i < 32; i++) step(1, 5'(i), $urandom, 0, 0, 0);
    h0 = hs_cnt;
    step(0, 0, 0, 1, 1, 0);
    drain(1, 200);
    chk(hs_cnt - h0 == 33 + int'(CS), "full_handshakes", hs_cnt - h0, 33 + int'(CS));

    // overrun during emission, then a duplicate on index 5
    step(1, 2, 32'hA, 0, 0, 0);
    step(1, 9, 32'hB, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 4, 32'hC, 1, 1, 0);
    chk(busy === 1'b1, "busy_emit", 32'(busy), 1);
    d0 = dup_cnt;
    step(1, 5, 32'h55, 0, 0, 0);
    step(1, 5, 32'h56, 0, 0, 0);
    drain(0, 50);
    chk(dup_cnt - d0 == 1, "dup_pulses", dup_cnt - d0, 1);
    chk(overrunCount === 16'd1, "overrun_one", 32'(overrunCount), 1);
    step(0, 0, 0, 1, 1, 1);
    drain(0, 50);

    // disabled close drops the frame
    step(1, 2, 32'hDEAD, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    drain(0, 50);

    // reset in the middle of the data phase
    for (int i = 0; i < 10; i++) step(1, 5'(i * 3), $urandom, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    do_reset();
    chk(pktTVALID === 1'b0, "abort_tvalid", 32'(pktTVALID), 0);
    chk(busy === 1'b0, "abort_idle", 32'(busy), 0);
    step(0, 0, 0, 1, 1, 1);
    drain(0, 50);

    // sequence wrap
    for (int k = 0; k < 257; k++) begin
      step(0, 0, 0, 1, 1, 1);
      drain(0, 20);
    end

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
    end
    drain(0, 200);
    chk(pktTVALID === 1'b0, "end_idle", 32'(pktTVALID), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
